serial_adder: RTL

//  Bit-serial adder built around the existing single-bit fulladder cell, which is instantiated once.

---
 rtl/serial_adder.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder -- bit-serial adder around a single fulladder cell
//
// Purpose:
//   Accepts two WIDTH-bit operands, adds them LSB-first one bit per cycle
//   through one fulladder instance (carry kept in a flop), and presents the
//   WIDTH-bit sum plus final carry-out.
//
// Handshakes (both sides): a transfer happens on a posedge where valid and
//   ready are both 1. in_ready is high only in IDLE and out_valid only in
//   DONE; neither ready depends combinationally on the opposite valid.
//   out_sum/out_cout are held stable while out_valid=1 and out_ready=0.
//
// Optional feature:
//   SERIAL_ADDER_SUB_EN -- when defined, adds the in_sub port. in_sub=1 at
//   acceptance computes A - B (b inverted, carry-in forced to 1); out_cout=1
//   then means "no borrow". When undefined the block is add-only.
//
// Ports:
//   clk        in   1      clock, all state updates on posedge
//   rst        in   1      synchronous active-high reset
//   in_valid   in   1      operands valid
//   in_ready   out  1      block can accept operands (state == IDLE)
//   in_a       in   WIDTH  operand A
//   in_b       in   WIDTH  operand B
//   in_cin     in   1      initial carry-in
//   in_sub     in   1      subtract select (SERIAL_ADDER_SUB_EN only)
//   out_valid  out  1      result valid (state == DONE)
//   out_ready  in   1      consumer accepts result
//   out_sum    out  WIDTH  (A + B + cin) mod 2^WIDTH
//   out_cout   out  1      final carry-out
//
// Debug visibility: the FSM state is the enum signal `state` inside this
//   module, and the bit index is `count`.
// -----------------------------------------------------------------------------

// Single-bit full adder cell.
//   a, b, cin : addend bits and carry-in
//   s, cout   : sum bit and carry-out
module fulladder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             in_sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic [WIDTH-1:0] sum_shift;
    logic             carry;
    logic [CW-1:0]    count;

    logic             accept;
    logic             step;

    logic [WIDTH-1:0] b_load;
    logic             cin_load;

    logic             fa_s;
    logic             fa_cout;

    // ------------------------------------------------------------------
    // Operand conditioning at acceptance. Subtraction is A + ~B + 1, so
    // the inverted B goes into the shift register and the carry starts at 1.
    // ------------------------------------------------------------------
`ifdef SERIAL_ADDER_SUB_EN
    always_comb begin
        b_load   = in_b;
        cin_load = in_cin;
        if (in_sub) begin
            b_load   = ~in_b;
            cin_load = 1'b1;
        end
    end
`else
    always_comb begin
        b_load   = in_b;
        cin_load = in_cin;
    end
`endif

    // ------------------------------------------------------------------
    // The one and only full-adder cell: it always sees the LSBs of the
    // operand shift registers and the stored carry.
    // ------------------------------------------------------------------
    fulladder u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_cout)
    );

    // New sum bits enter at the MSB so that after WIDTH steps the first
    // (LSB) result bit has arrived at bit 0. WIDTH=1 has no bits to keep.
    generate
        if (WIDTH == 1) begin : g_sum_w1
            assign sum_shift = fa_s;
        end else begin : g_sum_wn
            assign sum_shift = {fa_s, sum_sh[WIDTH-1:1]};
        end
    endgenerate

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and control strobes
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        step       = 1'b0;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                // The last bit is summed on this edge, so the result is
                // complete when DONE is entered.
                if (count == LAST_BIT) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            count  <= '0;
        end else if (accept) begin
            a_sh   <= in_a;
            b_sh   <= b_load;
            carry  <= cin_load;
            count  <= '0;
        end else if (step) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            sum_sh <= sum_shift;
            carry  <= fa_cout;
            count  <= count + 1'b1;
        end
    end

    // The result registers double as the output holding registers; they
    // only change during RUN, so they stay stable throughout DONE.
    assign out_sum  = sum_sh;
    assign out_cout = carry;

endmodule
